// File: rtl/bcd_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bcd_tick_scheduler
// Brief    : Two-phase alternating-period tick scheduler owning a BCD up/down
//            digit pair; issues single-cycle enable ticks on clk.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_tick_scheduler #(
    parameter int CNT_W       = 16,
    parameter int PER_A       = 1000,
    parameter int PER_B       = 4000,
    parameter int PER_C       = 3000,
    parameter int PER_D       = 2000,
    parameter int PHASE_TICKS = 200,
    parameter int TC_W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            pause,
    input  logic            clear,
    output logic            tick,
    output logic            wrap_pulse,
    output logic [3:0]      up,
    output logic [3:0]      down,
    output logic            phase,
    output logic [TC_W-1:0] tick_cnt,
    output logic            busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_paused = 2'd2;

    // Terminal prescaler values (period minus one) for each schedule slot
    localparam logic [CNT_W-1:0] c_term_a = CNT_W'(PER_A - 1);
    localparam logic [CNT_W-1:0] c_term_b = CNT_W'(PER_B - 1);
    localparam logic [CNT_W-1:0] c_term_c = CNT_W'(PER_C - 1);
    localparam logic [CNT_W-1:0] c_term_d = CNT_W'(PER_D - 1);
    localparam logic [TC_W-1:0]  c_tc_last = TC_W'(PHASE_TICKS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_presc;
    logic             r_odd;
    logic             r_phase;
    logic [TC_W-1:0]  r_tick_cnt;
    logic [3:0]       r_up;
    logic [3:0]       r_down;
    logic             r_tick;
    logic             r_wrap;

    logic [CNT_W-1:0] w_term;
    logic             w_run_edge;
    logic             w_due;
    logic [3:0]       w_up_nxt;
    logic [3:0]       w_down_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (!clear && start) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (clear) begin
                    w_state_nxt = c_st_idle;
                end else if (pause) begin
                    w_state_nxt = c_st_paused;
                end
            end
            c_st_paused: begin
                if (clear) begin
                    w_state_nxt = c_st_idle;
                end else if (start && !pause) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Edges that leave RUN (clear/pause) do not advance the schedule
    assign w_run_edge = (r_state == c_st_run) && !clear && !pause;
    assign w_term     = r_phase ? (r_odd ? c_term_d : c_term_c)
                                : (r_odd ? c_term_b : c_term_a);
    assign w_due      = w_run_edge && (r_presc == w_term);

    assign w_up_nxt   = (r_up >= 4'd9) ? 4'd0 : r_up + 4'd1;
    assign w_down_nxt = ((r_down == 4'd0) || (r_down > 4'd9)) ? 4'd9 : r_down - 4'd1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_presc    <= '0;
            r_odd      <= 1'b0;
            r_phase    <= 1'b0;
            r_tick_cnt <= '0;
            r_up       <= 4'd0;
            r_down     <= 4'd9;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (w_due) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
                r_up    <= w_up_nxt;
                r_down  <= w_down_nxt;
                if (r_tick_cnt == c_tc_last) begin
                    r_tick_cnt <= '0;
                    r_phase    <= ~r_phase;
                    r_odd      <= 1'b0;
                    r_wrap     <= r_phase;
                end else begin
                    r_tick_cnt <= r_tick_cnt + TC_W'(1);
                    r_odd      <= ~r_odd;
                end
            end else if (w_run_edge) begin
                r_presc <= r_presc + CNT_W'(1);
            end
        end
    end

    assign tick       = r_tick;
    assign wrap_pulse = r_wrap;
    assign up         = r_up;
    assign down       = r_down;
    assign phase      = r_phase;
    assign tick_cnt   = r_tick_cnt;
    assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: doc/bcd_tick_scheduler.md
Name: bcd_tick_scheduler

Overview:
- Sequencing controller for the BCD up/down digit-counter pair.
- Produces single-cycle enable ticks on the system clock. No derived clocks.
- Tick spacing follows a two-phase, alternating-period schedule.
- Accepts start/pause/clear commands and owns the up (0→9) and down (9→0) digit registers. The display/datapath consumes `tick` and the digits.

Parameters:
- CNT_W, 16: prescaler width. All periods must be < 2^CNT_W.
- PER_A, 1000: phase-0 even-interval period, in clk cycles (≥2).
- PER_B, 4000: phase-0 odd-interval period (≥2).
- PER_C, 3000: phase-1 even-interval period (≥2).
- PER_D, 2000: phase-1 odd-interval period (≥2).
- PHASE_TICKS, 200: ticks per phase (1..2^TC_W-1).
- TC_W, 8: width of the `tick_cnt` output.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled; IDLE→RUN, or PAUSED→RUN (resume).
- pause  in  1  level-sampled; RUN→PAUSED.
- clear  in  1  level-sampled; any state→IDLE, digits reinitialised.
- tick  out  1  one-cycle enable pulse.
- wrap_pulse  out  1  high with the tick that completes phase 1.
- up  out  4  BCD up-count digit.
- down  out  4  BCD down-count digit.
- phase  out  1  current schedule phase (0/1).
- tick_cnt  out  TC_W  ticks issued in the current phase.
- busy  out  1  high in RUN or PAUSED.

Behaviour:
- **Reset** (rst=1 at edge; overrides all inputs):
  - state=IDLE, prescaler=0, interval index=even, phase=0, tick_cnt=0.
  - tick=0, wrap_pulse=0, up=4'd0, down=4'd9, busy=0.
- **States:** IDLE, RUN, PAUSED. Command priority: rst > clear > pause > start.
  - IDLE: start → RUN. pause is ignored.
  - RUN: clear → IDLE. pause → PAUSED. start is ignored.
  - PAUSED: clear → IDLE. start (with pause=0) → RUN. Prescaler, phase, interval index, tick_cnt and digits are all retained.
  - clear: same register values as reset.
- **Prescaler:** increments once per cycle in RUN only. Frozen in IDLE and PAUSED.
- **Current period:**
  - phase 0: even index → PER_A, odd index → PER_B.
  - phase 1: even index → PER_C, odd index → PER_D.
- **Tick generation:** when the prescaler equals (current period − 1) at a RUN edge:
  - prescaler clears to 0;
  - tick=1 for exactly the following cycle;
  - interval index toggles;
  - tick_cnt increments;
  - up/down update on that same edge, so new digit values are visible with tick.
- **Spacing:** the first tick after start from IDLE is asserted PER_A cycles after the start-sampling edge. Successive ticks are then spaced by the current period.
- **Phase change:** on the tick that brings tick_cnt to PHASE_TICKS:
  - tick_cnt resets to 0, phase toggles, interval index resets to even.
  - If leaving phase 1, wrap_pulse=1 coincident with that tick. The schedule then repeats indefinitely.
- **Pause timing:** pause sampled on an edge where a tick is due suppresses that tick. The tick is issued on the first RUN edge after resume; the remaining interval is preserved.
- **Digit arithmetic:**
  - up: 0..8 → +1; 9 → 0.
  - down: 1..9 → −1; 0 → 9.
  - Values above 9 are unreachable; if forced, up→0 and down→9 on the next tick.
- **Outputs:** tick and wrap_pulse are registered and never high in IDLE/PAUSED except for a pulse issued on the transition edge.

Test Plan:
(Parameters for all scenarios: PER_A=4, PER_B=8, PER_C=6, PER_D=5, PHASE_TICKS=3, CNT_W=8.)
1. Reset: assert rst 3 cycles with start=1 → tick=0, up=0, down=9, busy=0, phase=0, tick_cnt=0; start is ignored while rst=1.
2. Schedule: single-cycle start, then run →
   - tick intervals 4,8,4 (phase 0), then 6,5,6 (phase 1), then 4 again;
   - phase flips after tick 3;
   - wrap_pulse only with tick 6;
   - up=1..6 and down=8..3 across ticks 1..6.
3. Digit wrap: run 10 ticks → tick 9 gives up=9/down=0; tick 10 gives up=0/down=9.
4. Pause:
   - pause 2 cycles after tick 1 (of an 8-cycle interval), hold 10 cycles, then start → no tick during pause; next tick 6 RUN cycles after resume; digits unchanged during pause.
   - pause on the edge a tick is due → that tick appears one cycle after resume.
5. Clear mid-run: clear during phase 1 → next cycle busy=0, up=0, down=9, phase=0, tick_cnt=0; restart gives a first interval of 4.
6. Priority:
   - start+pause+clear together in RUN → IDLE.
   - start+pause in RUN → PAUSED.
   - start in RUN → no effect on interval timing.
   - pause in IDLE → remains IDLE.
